// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I datapath: sequences each instruction,
// drives datapath selects/enables, resolves branches and counts retirements.
module multicycle_controller #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 Zero,
    input  logic                 Lt,
    input  logic                 Ltu,
    input  logic                 MemReady,
    output logic                 MemReq,
    output logic                 MemWrite,
    output logic                 AdrSrc,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ALUOp,
    output logic [2:0]           ImmSrc,
    output logic                 IllegalInstr,
    output logic [CNT_WIDTH-1:0] InstrCount
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_EXECU    = 4'd8;
    localparam logic [3:0] S_JALR     = 4'd9;
    localparam logic [3:0] S_ALUWB    = 4'd10;
    localparam logic [3:0] S_BRANCH   = 4'd11;
    localparam logic [3:0] S_JAL      = 4'd12;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [3:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 retire;

    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        MemReq       = 1'b0;
        MemWrite     = 1'b0;
        AdrSrc       = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        RegWrite     = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        ALUOp        = 2'b00;
        ImmSrc       = 3'b000;
        IllegalInstr = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                MemReq    = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
                if (MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                // ALUOut <= OldPC + imm, the branch/jump target
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                if (op == OP_BRANCH)   ImmSrc = 3'b010;
                else if (op == OP_JAL) ImmSrc = 3'b011;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_LUI, OP_AUIPC:  state_d = S_EXECU;
                    OP_JALR:           state_d = S_JALR;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default: begin
                        IllegalInstr = 1'b1;
                        state_d      = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                if (op == OP_STORE) begin
                    ImmSrc  = 3'b001;
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                if (MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                MemReq   = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (MemReady) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECU: begin
                ImmSrc  = 3'b100;
                ALUSrcB = 2'b01;
                ALUSrcA = (op == OP_LUI) ? 2'b11 : 2'b01;
                state_d = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
                state_d   = S_JAL;
            end
            S_JAL: begin
                // link value OldPC + 4; JALR has already redirected the PC
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = (op == OP_JAL);
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                state_d = S_FETCH;
                retire  = 1'b1;
                case (funct3)
                    3'b000:  PCWrite = Zero;
                    3'b001:  PCWrite = !Zero;
                    3'b100:  PCWrite = Lt;
                    3'b101:  PCWrite = !Lt;
                    3'b110:  PCWrite = Ltu;
                    3'b111:  PCWrite = !Ltu;
                    default: begin
                        IllegalInstr = 1'b1;
                        retire       = 1'b0;
                    end
                endcase
            end
            default: state_d = S_FETCH;
        endcase
        if (rst) begin
            MemReq       = 1'b0;
            MemWrite     = 1'b0;
            IRWrite      = 1'b0;
            PCWrite      = 1'b0;
            RegWrite     = 1'b0;
            IllegalInstr = 1'b0;
            retire       = 1'b0;
        end
        cnt_d = retire ? cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1} : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign InstrCount = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction cycle schedules built from
// the control rules, compared every cycle against a 32-bit and a 4-bit counter instance.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  op = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic        Zero = 1'b0, Lt = 1'b0, Ltu = 1'b0, MemReady = 1'b0;

    logic MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, IllegalInstr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;
    logic [31:0] InstrCount;

    logic MemReq4, MemWrite4, AdrSrc4, IRWrite4, PCWrite4, RegWrite4, IllegalInstr4;
    logic [1:0] ResultSrc4, ALUSrcA4, ALUSrcB4, ALUOp4;
    logic [2:0] ImmSrc4;
    logic [3:0] InstrCount4;

    always #5 clk = ~clk;

    multicycle_controller #(.CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3),
        .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .MemReady(MemReady),
        .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ImmSrc(ImmSrc), .IllegalInstr(IllegalInstr),
        .InstrCount(InstrCount)
    );

    multicycle_controller #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3),
        .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .MemReady(MemReady),
        .MemReq(MemReq4), .MemWrite(MemWrite4), .AdrSrc(AdrSrc4),
        .IRWrite(IRWrite4), .PCWrite(PCWrite4), .RegWrite(RegWrite4),
        .ResultSrc(ResultSrc4), .ALUSrcA(ALUSrcA4), .ALUSrcB(ALUSrcB4),
        .ALUOp(ALUOp4), .ImmSrc(ImmSrc4), .IllegalInstr(IllegalInstr4),
        .InstrCount(InstrCount4)
    );

    localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RR = 7'b0110011;
    localparam logic [6:0] II = 7'b0010011, LUI = 7'b0110111, AUI = 7'b0010111;
    localparam logic [6:0] JR = 7'b1100111, BR = 7'b1100011, JL = 7'b1101111;

    wire [17:0] dut_vec = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, IllegalInstr};
    wire [17:0] dut4_vec = {MemReq4, MemWrite4, AdrSrc4, IRWrite4, PCWrite4, RegWrite4,
                            ResultSrc4, ALUSrcA4, ALUSrcB4, ALUOp4, ImmSrc4, IllegalInstr4};

    int checks = 0;
    int failures = 0;
    int model_cnt = 0;
    int ncyc = 0;
    logic [17:0] exp_vec = '0;
    logic exp_valid = 1'b0;

    // {MemReq,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,Illegal}
    function automatic logic [17:0] mk(input logic mq, mw, adr, irw, pcw, rw,
                                       input logic [1:0] rs, a, b, aop,
                                       input logic [2:0] imm, input logic ill);
        return {mq, mw, adr, irw, pcw, rw, rs, a, b, aop, imm, ill};
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            checks++;
            if (dut_vec !== exp_vec) begin
                failures++;
                $display("FAIL ctrl t=%0t got=%b want=%b", $time, dut_vec, exp_vec);
            end
            checks++;
            if (dut4_vec !== exp_vec) begin
                failures++;
                $display("FAIL ctrl4 t=%0t got=%b want=%b", $time, dut4_vec, exp_vec);
            end
            checks++;
            if (InstrCount !== 32'(model_cnt)) begin
                failures++;
                $display("FAIL count t=%0t got=%0d want=%0d", $time, InstrCount, model_cnt);
            end
            checks++;
            if (InstrCount4 !== 4'(model_cnt % 16)) begin
                failures++;
                $display("FAIL count4 t=%0t got=%0d want=%0d", $time, InstrCount4, model_cnt % 16);
            end
        end
    end

    task automatic lit(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic cyc(input logic [17:0] v, input logic mr, input logic r, input logic ret);
        rst = r;
        MemReady = mr;
        exp_vec = v;
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
        if (r) model_cnt = 0;
        else if (ret) model_cnt++;
        ncyc++;
    endtask

    task automatic wb();
        cyc(mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0), 1'b1, 1'b0, 1'b1);
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3,
                             input logic z, input logic l, input logic lu,
                             input int fw, input int dw, output int lat);
        logic [2:0] imm;
        logic legal, taken, bill, is_st;
        op = o; funct3 = f3; Zero = z; Lt = l; Ltu = lu;
        ncyc = 0;
        for (int i = 0; i < fw; i++)
            cyc(mk(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0), 1'b0, 1'b0, 1'b0);
        cyc(mk(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0), 1'b1, 1'b0, 1'b0);
        imm = (o == BR) ? 3'b010 : (o == JL) ? 3'b011 : 3'b000;
        legal = (o inside {LD, ST, RR, II, LUI, AUI, JR, BR, JL});
        cyc(mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,imm,!legal), 1'b1, 1'b0, 1'b0);
        if (legal) begin
            is_st = (o == ST);
            case (o)
                LD, ST: begin
                    cyc(mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,is_st ? 3'b001 : 3'b000,0),
                        1'b1, 1'b0, 1'b0);
                    for (int i = 0; i < dw; i++)
                        cyc(mk(1,is_st,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0),
                            1'b0, 1'b0, 1'b0);
                    cyc(mk(1,is_st,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0),
                        1'b1, 1'b0, is_st);
                    if (!is_st)
                        cyc(mk(0,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,0),
                            1'b1, 1'b0, 1'b1);
                end
                RR: begin
                    cyc(mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b000,0), 1'b1, 1'b0, 1'b0);
                    wb();
                end
                II: begin
                    cyc(mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,3'b000,0), 1'b1, 1'b0, 1'b0);
                    wb();
                end
                LUI, AUI: begin
                    cyc(mk(0,0,0,0,0,0,2'b00,(o == LUI) ? 2'b11 : 2'b01,2'b01,2'b00,3'b100,0),
                        1'b1, 1'b0, 1'b0);
                    wb();
                end
                JR: begin
                    cyc(mk(0,0,0,0,1,0,2'b10,2'b10,2'b01,2'b00,3'b000,0), 1'b1, 1'b0, 1'b0);
                    cyc(mk(0,0,0,0,0,0,2'b00,2'b01,2'b10,2'b00,3'b000,0), 1'b1, 1'b0, 1'b0);
                    wb();
                end
                JL: begin
                    cyc(mk(0,0,0,0,1,0,2'b00,2'b01,2'b10,2'b00,3'b000,0), 1'b1, 1'b0, 1'b0);
                    wb();
                end
                default: begin
                    bill = (f3 == 3'b010) || (f3 == 3'b011);
                    case (f3)
                        3'b000: taken = z;
                        3'b001: taken = !z;
                        3'b100: taken = l;
                        3'b101: taken = !l;
                        3'b110: taken = lu;
                        3'b111: taken = !lu;
                        default: taken = 1'b0;
                    endcase
                    cyc(mk(0,0,0,0,taken,0,2'b00,2'b10,2'b00,2'b01,3'b000,bill),
                        1'b1, 1'b0, !bill);
                end
            endcase
        end
        lat = ncyc;
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        MemReady = 1'b1;
        @(posedge clk);
        #1;
        cyc(mk(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0), 1'b1, 1'b1, 1'b0);
        lit("reset_count", int'(InstrCount), 0);

        run_instr(RR, 3'b000, 0, 0, 0, 0, 0, lat);
        lit("add_latency", lat, 4);
        lit("add_count", int'(InstrCount), 1);
        run_instr(LD, 3'b010, 0, 0, 0, 0, 3, lat);
        lit("lw_latency", lat, 8);
        run_instr(BR, 3'b001, 1, 0, 0, 0, 0, lat);
        lit("bne_nt_latency", lat, 3);
        run_instr(BR, 3'b001, 0, 0, 0, 0, 0, lat);
        lit("bne_t_count", int'(InstrCount), 4);
        run_instr(JL, 3'b000, 0, 0, 0, 0, 0, lat);
        lit("jal_latency", lat, 4);
        run_instr(JR, 3'b000, 0, 0, 0, 0, 0, lat);
        lit("jalr_latency", lat, 5);
        run_instr(7'b0000000, 3'b000, 0, 0, 0, 0, 0, lat);
        lit("illegal_op_latency", lat, 2);
        run_instr(BR, 3'b010, 1, 1, 1, 0, 0, lat);
        lit("illegal_br_count", int'(InstrCount), 6);
        run_instr(ST, 3'b010, 0, 0, 0, 0, 0, lat);
        lit("sw_latency", lat, 4);
        run_instr(II, 3'b000, 0, 0, 0, 0, 0, lat);
        run_instr(LUI, 3'b000, 0, 0, 0, 0, 0, lat);
        run_instr(AUI, 3'b000, 0, 0, 0, 0, 0, lat);
        run_instr(BR, 3'b100, 0, 1, 0, 0, 0, lat);
        run_instr(BR, 3'b111, 0, 0, 1, 0, 0, lat);
        run_instr(BR, 3'b110, 0, 0, 1, 0, 0, lat);
        run_instr(BR, 3'b101, 0, 0, 0, 0, 0, lat);
        run_instr(RR, 3'b000, 0, 0, 0, 2, 0, lat);
        lit("fetch_wait_latency", lat, 6);
        lit("mid_count", int'(InstrCount), 15);

        // store abandoned by reset while waiting in MEMWRITE
        op = ST; funct3 = 3'b010;
        cyc(mk(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0), 1'b1, 1'b0, 1'b0);
        cyc(mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0), 1'b1, 1'b0, 1'b0);
        cyc(mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b001,0), 1'b1, 1'b0, 1'b0);
        cyc(mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0), 1'b0, 1'b0, 1'b0);
        cyc(mk(0,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0), 1'b0, 1'b1, 1'b0);
        lit("rst_mid_count", int'(InstrCount), 0);
        cyc(mk(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0), 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 16; k++)
            run_instr(RR, 3'b000, 0, 0, 0, 0, 0, lat);
        lit("wrap_count4", int'(InstrCount4), 0);
        lit("wrap_count32", int'(InstrCount), 16);

        exp_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
